// File: rtl/channel_rng.sv
// Pseudo-random integer source: Fibonacci LFSR scaled into [cfg_lo, cfg_lo + cfg_span - 1],
// delivered through a two-stage valid/ready pipeline with a threshold hit flag and hit counter.
module channel_rng #(
    parameter int unsigned       LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'h0043,
    parameter int unsigned       OUT_W  = 7,
    parameter int unsigned       CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_value,
    input  logic [OUT_W-1:0]  cfg_span,
    input  logic [OUT_W-1:0]  cfg_lo,
    input  logic [OUT_W-1:0]  cfg_thresh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_hit,
    output logic [CNT_W-1:0]  hit_count,
    output logic [LFSR_W-1:0] lfsr_state
);

    localparam int unsigned       PROD_W     = LFSR_W + OUT_W;
    localparam logic [LFSR_W-1:0] LFSR_ONE   = LFSR_W'(1);
    localparam logic [LFSR_W-1:0] RESET_SEED = (SEED == '0) ? LFSR_ONE : SEED;

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [LFSR_W-1:0] seed_fix;
    logic              s1_valid_q;
    logic [OUT_W-1:0]  s1_prod_q;
    logic [PROD_W-1:0] prod_full;
    logic [OUT_W-1:0]  prod_hi;
    logic [OUT_W-1:0]  out_sum;
    logic              adv;
    logic              drain;
    logic              out_fire;

    always_comb begin
        lfsr_nxt = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
        // Guard against a non-maximal tap mask collapsing the register to zero.
        if (lfsr_nxt == '0) begin
            lfsr_nxt = LFSR_ONE;
        end
        seed_fix = (seed_value == '0) ? LFSR_ONE : seed_value;

        // Multiply-and-shift maps the LFSR value uniformly onto [0, cfg_span).
        prod_full = PROD_W'(lfsr_q) * PROD_W'(cfg_span);
        prod_hi   = OUT_W'(prod_full >> LFSR_W);
        out_sum   = s1_prod_q + cfg_lo;

        adv      = enable && (!out_valid || out_ready);
        drain    = !enable && out_valid && out_ready;
        out_fire = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q     <= RESET_SEED;
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_hit    <= 1'b0;
            hit_count  <= '0;
        end else if (seed_load) begin
            // In-flight words belong to the old sequence and are discarded.
            lfsr_q     <= seed_fix;
            s1_valid_q <= 1'b0;
            out_valid  <= 1'b0;
            hit_count  <= '0;
        end else begin
            if (adv) begin
                s1_prod_q  <= prod_hi;
                s1_valid_q <= 1'b1;
                lfsr_q     <= lfsr_nxt;
                out_data   <= out_sum;
                out_hit    <= (out_sum < cfg_thresh);
                out_valid  <= s1_valid_q;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (out_fire && out_hit && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
        end
    end

    assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_channel_rng.sv
// Bench for channel_rng: directed phases with literal expectations, plus a stream-level model
// that predicts every visible word and the hit count from seed and configuration alone.
module tb_channel_rng;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        seed_load = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] seed_value = 16'h0000;
    logic [6:0]  cfg_span = 7'd100;
    logic [6:0]  cfg_lo = 7'd1;
    logic [6:0]  cfg_thresh = 7'd0;

    logic        out_valid, out_hit, out_valid4, out_hit4;
    logic [6:0]  out_data, out_data4;
    logic [31:0] hit_count;
    logic [3:0]  hit_count4;
    logic [15:0] lfsr_state, lfsr_state4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    channel_rng dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .cfg_span   (cfg_span),
        .cfg_lo     (cfg_lo),
        .cfg_thresh (cfg_thresh),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_hit    (out_hit),
        .hit_count  (hit_count),
        .lfsr_state (lfsr_state)
    );

    channel_rng #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .cfg_span   (cfg_span),
        .cfg_lo     (cfg_lo),
        .cfg_thresh (cfg_thresh),
        .out_valid  (out_valid4),
        .out_ready  (out_ready),
        .out_data   (out_data4),
        .out_hit    (out_hit4),
        .hit_count  (hit_count4),
        .lfsr_state (lfsr_state4)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    function automatic int unsigned word(input logic [15:0] s, input int unsigned span,
                                         input int unsigned lo);
        int unsigned scaled;
        scaled = (int'(s) * span) >> 16;
        return (scaled + lo) % 128;
    endfunction

    // Stream model: m_lfsr is the LFSR value behind the next word the consumer will see.
    logic [15:0] m_lfsr = 16'h0043;
    int unsigned m_span = 100, m_lo = 1, m_thresh = 0;
    longint      m_count = 0;

    always @(negedge clk) begin
        int unsigned w;
        logic        h;
        w = word(m_lfsr, m_span, m_lo);
        h = (w < m_thresh);
        if (out_valid) begin
            check("stream data", out_data, w);
            check("stream hit", out_hit, h);
            check("twin data", out_data4, out_data);
            check("twin hit", out_hit4, out_hit);
        end
        check("hit_count", hit_count, m_count);
        check("hit_count 4-bit", hit_count4, (m_count > 15) ? 15 : m_count);
        check("twin valid", out_valid4, out_valid);
        check("twin lfsr", lfsr_state4, lfsr_state);
        if (reset || seed_load) begin
            m_lfsr   = reset ? 16'h0043 : ((seed_value == 0) ? 16'h0001 : seed_value);
            m_count  = 0;
            m_span   = cfg_span;
            m_lo     = cfg_lo;
            m_thresh = cfg_thresh;
        end else if (out_valid && out_ready) begin
            if (h) m_count++;
            m_lfsr = step(m_lfsr);
        end
    end

    initial begin
        int zero_seen, early, frozen, changes, bad;
        logic [6:0]  d0;
        logic [15:0] prev;

        // Reset and first words
        tick(2);
        check("reset lfsr", lfsr_state, 16'h0043);
        check("reset valid", out_valid, 0);
        check("reset data", out_data, 0);
        check("reset hit", out_hit, 0);
        check("reset hit_count", hit_count, 0);
        reset = 1'b0;
        enable = 1'b1;
        tick();
        check("latency edge1 valid", out_valid, 0);
        check("lfsr after 1 adv", lfsr_state, 16'h0086);
        tick();
        check("latency edge2 valid", out_valid, 1);
        check("first word", out_data, 1);
        check("first hit", out_hit, 0);
        tick();
        check("second word", out_data, 1);

        // Seed 0x8000, threshold 51
        seed_value = 16'h8000;
        cfg_thresh = 7'd51;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check("seed lfsr", lfsr_state, 16'h8000);
        check("seed valid cleared", out_valid, 0);
        check("seed hit_count cleared", hit_count, 0);
        tick();
        check("seed+2 valid", out_valid, 0);
        check("seed+2 lfsr", lfsr_state, 16'h0001);
        tick();
        check("seed+3 valid", out_valid, 1);
        check("seed word1", out_data, 51);
        check("seed hit1", out_hit, 0);
        tick();
        check("seed word2", out_data, 1);
        check("seed hit2", out_hit, 1);
        check("hit_count after word1", hit_count, 0);
        tick();
        check("hit_count after word2", hit_count, 1);

        // Zero seed and full period
        seed_value = 16'h0000;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check("zero seed -> 1", lfsr_state, 16'h0001);
        zero_seen = 0;
        early = 0;
        for (int n = 1; n <= 65535; n++) begin
            tick();
            if (lfsr_state == 16'h0000) zero_seen++;
            if (n < 65535 && lfsr_state == 16'h0001) early++;
        end
        check("period never zero", zero_seen, 0);
        check("period no early repeat", early, 0);
        check("period return to 1", lfsr_state, 16'h0001);

        // Backpressure
        out_ready = 1'b0;
        d0 = out_data;
        prev = lfsr_state;
        frozen = 0;
        changes = 0;
        repeat (10) begin
            tick();
            if (out_data != d0) frozen++;
            if (lfsr_state != prev) changes++;
            prev = lfsr_state;
        end
        check("stall data frozen", frozen, 0);
        check("stall valid held", out_valid, 1);
        check("stall lfsr steps <= 1", (changes <= 1), 1);
        out_ready = 1'b1;
        tick(20);

        // Drain with enable low
        enable = 1'b0;
        prev = lfsr_state;
        tick();
        check("drain valid", out_valid, 0);
        check("drain lfsr held", lfsr_state, prev);
        tick();
        check("idle valid", out_valid, 0);
        enable = 1'b1;
        tick(10);

        // Span 0 -> constant lo
        seed_value = 16'h1234;
        cfg_span = 7'd0;
        cfg_lo = 7'd42;
        cfg_thresh = 7'd0;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        tick(2);
        check("span0 valid", out_valid, 1);
        check("span0 word", out_data, 42);
        tick(10);

        // Span 127, lo 100 wraps mod 128
        seed_value = 16'hACE1;
        cfg_span = 7'd127;
        cfg_lo = 7'd100;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        tick(2);
        check("wrap first word", out_data, 57);
        bad = 0;
        repeat (30) begin
            if (!(out_data >= 7'd100 || out_data <= 7'd98)) bad++;
            tick();
        end
        check("wrap range", bad, 0);

        // Every beat hits; 4-bit counter saturates
        seed_value = 16'h5A5A;
        cfg_span = 7'd100;
        cfg_lo = 7'd0;
        cfg_thresh = 7'd127;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        tick(2);
        tick(15);
        check("all hit count 15", hit_count, 15);
        check("4-bit count 15", hit_count4, 15);
        tick(5);
        check("all hit count 20", hit_count, 20);
        check("4-bit saturated", hit_count4, 15);

        // Reset mid-stream
        reset = 1'b1;
        tick();
        check("midreset valid", out_valid, 0);
        check("midreset lfsr", lfsr_state, 16'h0043);
        check("midreset data", out_data, 0);
        check("midreset hit", out_hit, 0);
        check("midreset hit_count", hit_count, 0);
        check("midreset hit_count4", hit_count4, 0);
        reset = 1'b0;
        enable = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
